// File: rtl/sd_write_stream_dat.sv
// SDIO 4-bit DAT transmit engine: preamble, start nibble, payload, per-lane CRC16, end nibble.
// Optional block abort is compiled in with `define SD_WRITE_ABORT_EN.
module sd_write_stream_dat #(
    parameter int WAIT_CLOCKS = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       sd_clock,
    input  logic       write_strobe,
    input  logic [8:0] data_count,
    output logic       byte_request,
    input  logic [7:0] byte_in,
    input  logic       abort,
    output logic [3:0] sd_data,
    output logic       sd_data_oe,
    output logic       busy,
    output logic       write_all_strobe,
    output logic       aborted
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WAIT  = 3'd1;
    localparam logic [2:0] S_PRE   = 3'd2;
    localparam logic [2:0] S_START = 3'd3;
    localparam logic [2:0] S_DATA  = 3'd4;
    localparam logic [2:0] S_CRC   = 3'd5;
    localparam logic [2:0] S_END   = 3'd6;
    localparam logic [2:0] S_DONE  = 3'd7;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CLOCKS - 1);
    localparam logic [3:0] NIB_IDLE  = 4'hF;

    logic [2:0]       sclk_q;
    logic             fall;
    logic [2:0]       state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [9:0]       nib_q, nib_d;
    logic [9:0]       ntot_q, ntot_d;
    logic [8:0]       bcnt_q, bcnt_d;
    logic [7:0]       byte_q;
    logic [3:0]       lo_q, lo_d;
    logic [3:0][15:0] crc_q, crc_d;
    logic [3:0]       sd_q, sd_d;
    logic             oe_q, oe_d;
    logic             req_q, req_d;
    logic             busy_q, busy_d;
    logic             wall_q, wall_d;
    logic             abrt_q, abrt_d;
    logic             abp_q, abp_d;
    logic             abort_req;
    logic             accept;
    logic             cut;
    logic [3:0]       nv;
    logic [3:0]       cidx;

`ifdef SD_WRITE_ABORT_EN
    assign abort_req = abort;
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_req    = 1'b0;
`endif

    function automatic logic [15:0] crc16_step(
        input logic [15:0] c,
        input logic        b
    );
        logic fb;
        fb = b ^ c[15];
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    // sclk_q[2] is the oldest sample; a falling edge is old=1, newer=0
    assign fall   = sclk_q[2] & ~sclk_q[1];
    assign accept = (state_q == S_IDLE) && write_strobe
                    && (data_count != 9'd0);
    assign cut    = abp_q && (state_q != S_IDLE)
                    && (state_q != S_END) && (state_q != S_DONE);
    assign nv     = nib_q[0] ? lo_q : byte_q[7:4];
    assign cidx   = 4'd15 - nib_q[3:0];

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        nib_d   = nib_q;
        ntot_d  = ntot_q;
        bcnt_d  = bcnt_q;
        lo_d    = lo_q;
        crc_d   = crc_q;
        sd_d    = sd_q;
        oe_d    = oe_q;
        busy_d  = busy_q;
        abrt_d  = abrt_q;
        req_d   = 1'b0;
        wall_d  = 1'b0;
        abp_d   = abp_q | (abort_req & busy_q);

        if (accept) begin
            busy_d  = 1'b1;
            abrt_d  = 1'b0;
            abp_d   = 1'b0;
            crc_d   = '0;
            bcnt_d  = data_count;
            ntot_d  = {data_count, 1'b0};
            wcnt_d  = 4'd0;
            state_d = (WAIT_CLOCKS == 0) ? S_PRE : S_WAIT;
        end else if (fall && cut) begin
            sd_d    = NIB_IDLE;
            state_d = S_DONE;
        end else if (fall) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d = S_IDLE;
                end
                S_WAIT: begin
                    wcnt_d = wcnt_q + 4'd1;
                    if (wcnt_q == WAIT_LAST) begin
                        state_d = S_PRE;
                    end
                end
                S_PRE: begin
                    oe_d    = 1'b1;
                    sd_d    = NIB_IDLE;
                    state_d = S_START;
                end
                S_START: begin
                    sd_d    = 4'h0;
                    req_d   = 1'b1;
                    bcnt_d  = bcnt_q - 9'd1;
                    nib_d   = 10'd0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    sd_d = nv;
                    for (int i = 0; i < 4; i++) begin
                        crc_d[i] = crc16_step(crc_q[i], nv[i]);
                    end
                    // low nibble is parked so the prefetch can overwrite byte_q
                    if (!nib_q[0]) begin
                        lo_d = byte_q[3:0];
                        if (bcnt_q != 9'd0) begin
                            req_d  = 1'b1;
                            bcnt_d = bcnt_q - 9'd1;
                        end
                    end
                    if (nib_q == ntot_q - 10'd1) begin
                        nib_d   = 10'd0;
                        state_d = S_CRC;
                    end else begin
                        nib_d = nib_q + 10'd1;
                    end
                end
                S_CRC: begin
                    sd_d  = {crc_q[3][cidx], crc_q[2][cidx],
                             crc_q[1][cidx], crc_q[0][cidx]};
                    nib_d = nib_q + 10'd1;
                    if (nib_q[3:0] == 4'hF) begin
                        state_d = S_END;
                    end
                end
                S_END: begin
                    sd_d    = NIB_IDLE;
                    state_d = S_DONE;
                end
                S_DONE: begin
                    oe_d    = 1'b0;
                    sd_d    = NIB_IDLE;
                    wall_d  = 1'b1;
                    busy_d  = 1'b0;
                    abrt_d  = abp_q;
                    abp_d   = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sclk_q  <= 3'b000;
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            nib_q   <= 10'd0;
            ntot_q  <= 10'd0;
            bcnt_q  <= 9'd0;
            byte_q  <= 8'd0;
            lo_q    <= 4'd0;
            crc_q   <= '0;
            sd_q    <= NIB_IDLE;
            oe_q    <= 1'b0;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            wall_q  <= 1'b0;
            abrt_q  <= 1'b0;
            abp_q   <= 1'b0;
        end else begin
            sclk_q  <= {sclk_q[1:0], sd_clock};
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            nib_q   <= nib_d;
            ntot_q  <= ntot_d;
            bcnt_q  <= bcnt_d;
            lo_q    <= lo_d;
            crc_q   <= crc_d;
            sd_q    <= sd_d;
            oe_q    <= oe_d;
            req_q   <= req_d;
            busy_q  <= busy_d;
            wall_q  <= wall_d;
            abrt_q  <= abrt_d;
            abp_q   <= abp_d;
            if (req_q) begin
                byte_q <= byte_in;
            end
        end
    end

    assign byte_request     = req_q;
    assign sd_data          = sd_q;
    assign sd_data_oe       = oe_q;
    assign busy             = busy_q;
    assign write_all_strobe = wall_q;
    assign aborted          = abrt_q;

endmodule

// File: tb/tb_sd_write_stream_dat.sv
// Bench for sd_write_stream_dat: directed and randomized blocks compared
// against a nibble-stream model whose CRC16 is a polynomial remainder.
module tb_sd_write_stream_dat;

    localparam int WAITC = 2;

    logic       clock        = 1'b0;
    logic       reset_n      = 1'b0;
    logic       sd_clock     = 1'b1;
    logic       write_strobe = 1'b0;
    logic [8:0] data_count   = 9'd0;
    logic [7:0] byte_in      = 8'd0;
    logic       abort        = 1'b0;
    logic       byte_request;
    logic [3:0] sd_data;
    logic       sd_data_oe;
    logic       busy;
    logic       write_all_strobe;
    logic       aborted;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:511];
    int         ridx = 0;
    int         nreq = 0;
    int         nwall = 0;
    logic       last_ab = 1'b0;
    logic [4:0] exp_q [$];

    sd_write_stream_dat #(.WAIT_CLOCKS(WAITC)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .sd_clock         (sd_clock),
        .write_strobe     (write_strobe),
        .data_count       (data_count),
        .byte_request     (byte_request),
        .byte_in          (byte_in),
        .abort            (abort),
        .sd_data          (sd_data),
        .sd_data_oe       (sd_data_oe),
        .busy             (busy),
        .write_all_strobe (write_all_strobe),
        .aborted          (aborted)
    );

    always #5 clock = ~clock;

    // payload buffer: answers a request with the next byte one clock later
    always @(negedge clock) begin
        if (byte_request) begin
            byte_in = mem[ridx % 512];
            ridx++;
            nreq++;
        end
        if (write_all_strobe) begin
            nwall++;
            last_ab = aborted;
        end
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sd_cycle();
        sd_clock = 1'b1;
        repeat (4) @(negedge clock);
        sd_clock = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    // expected {oe, dat} once per sd_clock fall; cut >= 0 truncates after cut data nibbles
    task automatic build_exp(input int n, input int cut);
        logic [3:0]  d [$];
        logic [15:0] crc [4];
        logic [16:0] r;
        int          nd;
        exp_q.delete();
        for (int b = 0; b < n; b++) begin
            d.push_back(mem[b][7:4]);
            d.push_back(mem[b][3:0]);
        end
        for (int i = 0; i < 4; i++) begin
            r = '0;
            for (int k = 0; k < d.size() + 16; k++) begin
                r = {r[15:0], (k < d.size()) ? d[k][i] : 1'b0};
                if (r[16]) r = r ^ 17'h11021;
            end
            crc[i] = r[15:0];
        end
        nd = (cut < 0) ? d.size() : cut;
        repeat (WAITC) exp_q.push_back(5'h0F);
        exp_q.push_back(5'h1F);
        exp_q.push_back(5'h10);
        for (int k = 0; k < nd; k++) exp_q.push_back({1'b1, d[k]});
        if (cut < 0) begin
            for (int j = 0; j < 16; j++) begin
                exp_q.push_back({1'b1, crc[3][15-j], crc[2][15-j],
                                 crc[1][15-j], crc[0][15-j]});
            end
        end
        exp_q.push_back(5'h1F);
        exp_q.push_back(5'h0F);
    endtask

    task automatic run_block(input string nm, input int n, input int cut,
                             input int abort_k, input int pause_at,
                             input int strobe_at, input int reset_at);
        logic [4:0] obs;
        logic [4:0] hold;
        logic       stable;
        int         exp_req;
        build_exp(n, cut);
        exp_req = (cut < 0) ? n : (cut / 2 + 1);
        ridx  = 0;
        nreq  = 0;
        nwall = 0;
        last_ab = 1'b0;
        data_count   = n[8:0];
        write_strobe = 1'b1;
        @(negedge clock);
        write_strobe = 1'b0;
        data_count   = 9'd0;
        @(negedge clock);
        chk({nm, "_busy_set"}, 32'(busy), 32'd1);
        for (int k = 0; k < exp_q.size(); k++) begin
            sd_cycle();
            obs = {sd_data_oe, sd_data};
            chk($sformatf("%s_nib%0d", nm, k), 32'(obs), 32'(exp_q[k]));
            if (k == reset_at) begin
                reset_n = 1'b0;
                #1;
                chk({nm, "_rst_oe"}, 32'(sd_data_oe), 32'd0);
                chk({nm, "_rst_dat"}, 32'(sd_data), 32'hF);
                chk({nm, "_rst_busy"}, 32'(busy), 32'd0);
                @(negedge clock);
                reset_n = 1'b1;
                repeat (40) @(negedge clock);
                chk({nm, "_rst_no_wall"}, 32'(nwall), 32'd0);
                return;
            end
            if (k == abort_k) begin
                abort = 1'b1;
                @(negedge clock);
                abort = 1'b0;
            end
            if (k == strobe_at) begin
                data_count   = 9'd5;
                write_strobe = 1'b1;
                @(negedge clock);
                write_strobe = 1'b0;
                data_count   = 9'd0;
            end
            if (k == pause_at) begin
                hold   = {sd_data_oe, sd_data};
                stable = 1'b1;
                repeat (100) begin
                    @(negedge clock);
                    if ({sd_data_oe, sd_data} !== hold) stable = 1'b0;
                end
                chk({nm, "_pause_stable"}, 32'(stable), 32'd1);
            end
        end
        repeat (4) @(negedge clock);
        chk({nm, "_nreq"}, 32'(nreq), 32'(exp_req));
        chk({nm, "_nwall"}, 32'(nwall), 32'd1);
        chk({nm, "_aborted"}, 32'(last_ab), 32'(cut >= 0));
        chk({nm, "_busy_clr"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        int acut;
        repeat (3) @(negedge clock);
        chk("rst_dat", 32'(sd_data), 32'hF);
        chk("rst_oe", 32'(sd_data_oe), 32'd0);
        chk("rst_req", 32'(byte_request), 32'd0);
        chk("rst_wall", 32'(write_all_strobe), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        mem[0] = 8'hA5;
        run_block("one_a5", 1, -1, -1, -1, -1, -1);

        for (int i = 0; i < 511; i++) mem[i] = 8'hFF;
        run_block("max_ff", 511, -1, -1, -1, -1, -1);

        for (int t = 0; t < 3; t++) begin
            n = $urandom_range(2, 40);
            for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
            run_block($sformatf("rnd%0d", t), n, -1, -1,
                      (t == 1) ? WAITC + 2 + $urandom_range(0, 2 * n - 1) : -1,
                      (t == 2) ? WAITC + 2 + $urandom_range(0, 2 * n - 1) : -1,
                      -1);
        end

        nreq = 0;
        data_count   = 9'd0;
        write_strobe = 1'b1;
        @(negedge clock);
        write_strobe = 1'b0;
        repeat (4) sd_cycle();
        chk("zero_busy", 32'(busy), 32'd0);
        chk("zero_oe", 32'(sd_data_oe), 32'd0);
        chk("zero_dat", 32'(sd_data), 32'hF);
        chk("zero_req", 32'(nreq), 32'd0);

        n = 4;
        for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
        run_block("rst_crc", n, -1, -1, -1, -1, WAITC + 2 + 2 * n + 5);

        n = $urandom_range(3, 20);
        for (int i = 0; i < n; i++) mem[i] = 8'($urandom);
        run_block("after_rst", n, -1, -1, -1, -1, -1);

        for (int i = 0; i < 10; i++) mem[i] = 8'($urandom);
`ifdef SD_WRITE_ABORT_EN
        acut = 6;
`else
        acut = -1;
`endif
        run_block("abort", 10, acut, WAITC + 2 + 5, -1, -1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_write_stream_dat.md
# sd_write_stream_dat

Transmit-side SDIO data-line engine: sends a block of bytes from the card to the host on DAT[3:0] in 4-bit mode. Each block is framed with a start nibble, the payload (high nibble first), a per-lane CRC16 and an end nibble. It sits beside the data-line receiver in the SDIO slave. It pulls payload bytes from a buffer through a one-cycle-latency request handshake and drives the pads through an output enable. All logic runs on the system clock; sd_clock is sampled, not used as a clock.

## Interface
- WAIT_CLOCKS, 2: number of sd_clock falling edges between write_strobe and the preamble nibble (0..15).

- clock  in  1  system clock; must be at least 6x sd_clock frequency.
- reset_n  in  1  asynchronous active-low reset.
- sd_clock  in  1  raw SD clock pin; synchronized internally with two flops.
- write_strobe  in  1  one-cycle pulse that starts a block.
- data_count  in  9  payload bytes (1..511), sampled at write_strobe.
- byte_request  out  1  one-cycle pulse requesting the next payload byte.
- byte_in  in  8  payload byte; must be valid exactly one clock after byte_request.
- abort  in  1  one-cycle stop request; honoured only with SD_WRITE_ABORT_EN.
- sd_data  out  4  DAT[3:0] drive value.
- sd_data_oe  out  1  pad output enable.
- busy  out  1  high from the accepted write_strobe until write_all_strobe.
- write_all_strobe  out  1  one-cycle pulse at the end of the block.
- aborted  out  1  valid with write_all_strobe; 1 means the block was cut short.

## Operation
- Falling-edge detect: fall = sd_clock3==1 && sd_clock2==0. All DAT updates occur only on the fall cycle.
- write_strobe is accepted only when idle and data_count!=0; otherwise it is ignored with no response. Acceptance clears the four CRC16 lanes (sd_crc16, x^16+x^12+x^5+1, init 0) and sets busy.
- State machine (each transition happens on fall):
  - IDLE: wait for write_strobe.
  - WAIT: count WAIT_CLOCKS falls; skipped when the value is 0.
  - PRE: sd_data_oe=1, sd_data=4'hF.
  - START: sd_data=4'h0; pulse byte_request; latch byte_in next clock into the shift register.
  - DATA: 2*data_count nibbles.
    - An even nibble drives byte[7:4]; an odd nibble drives byte[3:0].
    - On each even nibble, when more bytes remain, pulse byte_request so the next byte is latched before the following even nibble.
    - Each driven lane bit feeds its own CRC lane (enable for one clock).
  - CRC: 16 nibbles; lane i drives crc16[i][15..0], MSB first. CRC is not updated.
  - END: sd_data=4'hF.
  - On the next fall: sd_data_oe=0, sd_data=4'hF, pulse write_all_strobe with aborted=0, clear busy, return to IDLE.
- Nibble counter is 10 bits wide. The byte counter decrements once per byte and never wraps below 0.
- Exactly data_count byte_request pulses are issued per completed block.

## Timing
- Reset values: sd_data=4'hF, sd_data_oe=0, byte_request=0, write_all_strobe=0, busy=0, aborted=0, state IDLE.
- sd_data and sd_data_oe are registered. They change 3 clocks after the real sd_clock falling edge (2 sync flops plus the output register).
- byte_request fires on the fall cycle; byte_in is captured on the following clock.
- write_strobe arriving on the same cycle as a fall is registered first; WAIT counting starts at the next fall.
- reset_n asserted mid-block returns all outputs to their reset values immediately. No write_all_strobe is issued.
- sd_clock stopped: the FSM holds its state and DAT holds its value indefinitely.

## Configuration
- SD_WRITE_ABORT_EN defined:
  - abort while busy forces END on the next fall (4'hF), then release.
  - write_all_strobe fires with aborted=1.
  - No further byte_request pulses are issued.
  - abort during PRE or START still passes through END.
  - abort while idle is ignored.
- SD_WRITE_ABORT_EN undefined:
  - the abort input is ignored, aborted is constant 0, and every block runs to completion.

## Test plan
- data_count=1, byte_in=8'hA5, WAIT_CLOCKS=2 -> after 2 falls: F, 0, A, 5, 16 CRC nibbles matching a software model, F; then oe drops; one byte_request; write_all_strobe with aborted=0.
- data_count=511, all bytes 8'hFF -> 1022 nibbles of 4'hF; each lane CRC equals the model value; 511 byte_request pulses.
- write_strobe with data_count=0, and write_strobe while busy -> no state change, no output activity.
- sd_clock paused for 100 clocks mid-DATA -> sd_data stable throughout; resumes with no skipped or duplicated nibble.
- reset_n pulsed low in the CRC phase -> sd_data_oe=0, sd_data=4'hF and busy=0 the same cycle; the next block transmits correctly.
- With SD_WRITE_ABORT_EN, abort after byte 3 of 10 -> next nibble is 4'hF, then oe=0; write_all_strobe with aborted=1; exactly 4 byte_request pulses (at most one prefetched).
